snn_lif_block: RTL
==================

# snn_lif_block

Time-multiplexed block of N leaky integrate-and-fire (LIF) neurons with run-time-fixed, compile-time-parametrised neuron constants.
- Accepts one N-bit input spike vector per time step over a valid/ready handshake.
- Updates each neuron's membrane potential sequentially, one neuron per cycle, and returns an N-bit output spike vector.
- Sits between the spike-source/AXI front end and downstream blocks; T instances chain to form a network.

## Interface
Parameters:
- N, 5: neurons in the block (≥1).
- W, 8: potential width in bits; V_0, V_REST, K_SYN must be < 2^W.
- TS, 20: time steps per run.
- V_0, 14: firing threshold.
- V_REST, 6: rest/reset potential, also the leak floor.
- V_LEAK, 1: leak subtracted per time step.
- K_SYN, 1: increment per input spike.
- RP, 1: refractory period in time steps (0 disables refractoriness).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input spike vector valid.
- in_ready  out  1  block can accept a vector.
- in_spikes  in  N  bit i drives neuron i.
- out_valid  out  1  output spike vector valid.
- out_ready  in  1  downstream accepts the output.
- out_spikes  out  N  bit i = neuron i fired this step.
- out_last  out  1  qualifies out_spikes for step TS-1.
- step  out  $clog2(TS)  index of the step currently held or being processed.

## Operation
- Storage per neuron:
  - v[i], W bits, reset value V_REST.
  - r[i], $clog2(RP+1) bits, reset value 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_spikes, set idx=0, go to RUN.
  - RUN: in_ready=0. Update neuron idx each cycle. At idx==N-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE and advance step.
- Neuron update for i=idx:
  - If r[i]≠0: r[i]−1, v[i]=V_REST, no spike, input ignored.
  - Else:
    - Leak: a = max(v[i]−V_LEAK, V_REST). Compute in W+1 bits; never below V_REST, never underflows.
    - Integrate: b = a + (in_spikes[i] ? K_SYN : 0), saturated to 2^W−1.
    - Fire: if b ≥ V_0, set spike bit i, v[i]=V_REST, r[i]=RP.
    - Otherwise v[i]=b.
- out_spikes is built bit by bit during RUN. It is cleared on entry to RUN and is stable throughout DONE.
- step:
  - Increments on every out handshake and wraps TS−1 → 0.
  - out_last = (step==TS−1) while in DONE.
  - After a wrap, potentials and refractory counters carry over; only reset clears them.
- Reset mid-operation: FSM returns to IDLE, all v=V_REST, r=0, step=0. The in-flight vector is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_spikes=0, out_last=0, step=0.
- Input handshake on edge k → RUN cycles k+1..k+N → out_valid=1 from edge k+N.
- out_valid and out_spikes hold while out_ready=0. No new input is accepted until the output handshake completes.
- Output handshake on edge m → in_ready=1 after edge m. Minimum period is N+2 cycles per step.
- in_ready and in_valid never combinationally depend on each other. out_valid does not depend on out_ready.
- in_valid asserted while in_ready=0: ignored. The source must hold the vector.

## Configuration
- SNN_LIF_POT_TAP_EN defined: adds ports
  - tap_valid out 1, high during each RUN cycle.
  - tap_idx out $clog2(N), equal to idx.
  - tap_v out W, the value written to v[idx] that cycle.
- Not defined: these ports and their logic are absent. Neuron behaviour is identical in both builds.

## Test plan
- Reset: assert reset 2 cycles mid-RUN. Required: outputs at reset values, step=0, and next output after one drive step shows v=7 via tap.
- Integrate-and-fire (K_SYN=3, RP=1): drive neuron 0 every step. Potential 9, 11, 13, then spike on step 4 (b=15 ≥ 14) → out_spikes=5'b00001 only on step 4.
- Refractory: continue the above drive. Step 5: no spike, v=6. Step 6: v=9. Next spike on step 9.
- Leak floor: no input for 10 steps from reset. v stays 6 for all neurons and out_spikes=0 throughout.
- Saturation (W=4, K_SYN=15): single input spike gives 6+15 → saturates to 15 ≥ 14 → spike, v=6.
- Back-pressure and wrap (TS=20): hold out_ready=0 for 7 cycles in DONE. out_spikes is stable and in_ready=0 throughout. Over 20 steps, out_last is high only on step 19 and step returns to 0.

Source files
------------

// File: rtl/snn_lif_block.sv
// snn_lif_block: N time-multiplexed leaky integrate-and-fire neurons, one neuron updated per cycle.
// Optional potential tap ports (tap_valid/tap_idx/tap_v) are enabled by defining SNN_LIF_POT_TAP_EN.
module snn_lif_block #(
    parameter int N      = 5,
    parameter int W      = 8,
    parameter int TS     = 20,
    parameter int V_0    = 14,
    parameter int V_REST = 6,
    parameter int V_LEAK = 1,
    parameter int K_SYN  = 1,
    parameter int RP     = 1,
    localparam int IDXW  = (N > 1) ? $clog2(N) : 1,
    localparam int STEPW = (TS > 1) ? $clog2(TS) : 1,
    localparam int RW    = (RP > 0) ? $clog2(RP + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_spikes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_spikes,
    output logic             out_last,
    output logic [STEPW-1:0] step
`ifdef SNN_LIF_POT_TAP_EN
    ,
    output logic             tap_valid,
    output logic [IDXW-1:0]  tap_idx,
    output logic [W-1:0]     tap_v
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0]     REST_V    = W'(V_REST);
    localparam logic [W-1:0]     V0_V      = W'(V_0);
    localparam logic [W:0]       REST_X    = (W + 1)'(V_REST);
    localparam logic [W:0]       LEAK_X    = (W + 1)'(V_LEAK);
    localparam logic [W:0]       KSYN_X    = (W + 1)'(K_SYN);
    localparam logic [W:0]       MAX_X     = {1'b0, {W{1'b1}}};
    localparam logic [RW-1:0]    RP_R      = RW'(RP);
    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(N - 1);
    localparam logic [STEPW-1:0] STEP_LAST = STEPW'(TS - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [N-1:0]      spk_in_q, spk_in_d;
    logic [N-1:0]      out_spikes_q, out_spikes_d;
    logic [STEPW-1:0]  step_q, step_d;
    logic [W-1:0]      v_q [N];
    logic [W-1:0]      v_d [N];
    logic [RW-1:0]     r_q [N];
    logic [RW-1:0]     r_d [N];

    logic [W:0]        v_ext;
    logic [W:0]        leak_v;
    logic [W:0]        sum_v;
    logic [W-1:0]      sat_v;
    logic [W-1:0]      upd_v;
    logic [RW-1:0]     upd_r;
    logic              upd_fire;

    // State register plus all datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= {IDXW{1'b0}};
            spk_in_q     <= {N{1'b0}};
            out_spikes_q <= {N{1'b0}};
            step_q       <= {STEPW{1'b0}};
            for (int i = 0; i < N; i++) begin
                v_q[i] <= REST_V;
                r_q[i] <= {RW{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            spk_in_q     <= spk_in_d;
            out_spikes_q <= out_spikes_d;
            step_q       <= step_d;
            for (int i = 0; i < N; i++) begin
                v_q[i] <= v_d[i];
                r_q[i] <= r_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            S_RUN: begin
                if (idx_q == IDX_LAST) state_d = S_DONE;
                else                   state_d = S_RUN;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
                else           state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state and step registers
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out_last  = (state_q == S_DONE) && (step_q == STEP_LAST);
    end

    assign out_spikes = out_spikes_q;
    assign step       = step_q;

    // Single-neuron LIF update for neuron idx_q; leak is floored at rest in W+1 bits
    always_comb begin
        v_ext = {1'b0, v_q[idx_q]};
        if (v_ext >= (REST_X + LEAK_X)) leak_v = v_ext - LEAK_X;
        else                            leak_v = REST_X;
        if (spk_in_q[idx_q]) sum_v = leak_v + KSYN_X;
        else                 sum_v = leak_v;
        if (sum_v > MAX_X) sat_v = {W{1'b1}};
        else               sat_v = sum_v[W-1:0];
        if (r_q[idx_q] != {RW{1'b0}}) begin
            upd_v    = REST_V;
            upd_r    = r_q[idx_q] - RW'(1);
            upd_fire = 1'b0;
        end else if (sat_v >= V0_V) begin
            upd_v    = REST_V;
            upd_r    = RP_R;
            upd_fire = 1'b1;
        end else begin
            upd_v    = sat_v;
            upd_r    = r_q[idx_q];
            upd_fire = 1'b0;
        end
    end

    // Datapath next values: latch input, write back one neuron per RUN cycle, advance step
    always_comb begin
        idx_d        = idx_q;
        spk_in_d     = spk_in_q;
        out_spikes_d = out_spikes_q;
        step_d       = step_q;
        v_d          = v_q;
        r_d          = r_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    spk_in_d     = in_spikes;
                    idx_d        = {IDXW{1'b0}};
                    out_spikes_d = {N{1'b0}};
                end else begin
                    spk_in_d     = spk_in_q;
                end
            end
            S_RUN: begin
                v_d[idx_q]          = upd_v;
                r_d[idx_q]          = upd_r;
                out_spikes_d[idx_q] = upd_fire;
                if (idx_q != IDX_LAST) idx_d = idx_q + IDXW'(1);
                else                   idx_d = idx_q;
            end
            S_DONE: begin
                if (out_ready) begin
                    if (step_q == STEP_LAST) step_d = {STEPW{1'b0}};
                    else                     step_d = step_q + STEPW'(1);
                end else begin
                    step_d = step_q;
                end
            end
            default: begin
                idx_d = {IDXW{1'b0}};
            end
        endcase
    end

`ifdef SNN_LIF_POT_TAP_EN
    // Tap mirrors the write-back of the neuron being updated
    always_comb begin
        tap_valid = (state_q == S_RUN);
        tap_idx   = idx_q;
        tap_v     = upd_v;
    end
`endif

endmodule
